// File: rtl/ps2kb_event_fifo.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and a first-word-fall-through
// event FIFO. Frames are checked for start, odd parity, stop and inter-edge timeout.
module ps2kb_event_fifo #(
   parameter int OVER_TIME   = 1000,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            device_clock,
   input  logic                            device_data,
   output logic                            event_valid,
   input  logic                            event_ready,
   output logic [7:0]                      keycode,
   output logic                            key_break,
   output logic                            key_extended,
   output logic                            key_error,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            overflow,
   input  logic                            clear_overflow,
   output logic                            irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(OVER_TIME + 1);

   // Synchronisers and edge detection
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   data_s;

   // Receiver state
   logic [3:0]    bit_cnt;
   logic [9:0]    frame;
   logic [TW-1:0] tcnt;
   logic          byte_stb;
   logic          err_stb;
   logic [7:0]    rx_byte;

   // Decoder state; event layout is {err, ext, brk, byte}
   logic          ext;
   logic          brk;
   logic          push;
   logic [10:0]   push_data;

   // FIFO state
   logic [10:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [10:0]   head;
   logic          do_push;
   logic          do_pop;
   logic [CW-1:0] next_count;
   logic [10:0]   next_head;

   assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Bring the asynchronous PS/2 lines into the clock domain
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_sync  <= '0;
         data_sync <= '0;
         clk_prev  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], device_clock};
         data_sync <= {data_sync[SYNC_STAGES-2:0], device_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   // Shift in frame bits on falling edges, check the frame, and abort stalled frames
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         frame    <= '0;
         tcnt     <= '0;
         byte_stb <= 1'b0;
         err_stb  <= 1'b0;
         rx_byte  <= '0;
      end else begin
         byte_stb <= 1'b0;
         err_stb  <= 1'b0;
         if (fall) begin
            tcnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               if (!frame[0] && (^frame[9:1]) && data_s) begin
                  byte_stb <= 1'b1;
                  rx_byte  <= frame[8:1];
               end else begin
                  err_stb <= 1'b1;
               end
            end else begin
               frame[bit_cnt] <= data_s;
               bit_cnt        <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            if (tcnt == TW'(OVER_TIME - 1)) begin
               tcnt    <= '0;
               bit_cnt <= '0;
               err_stb <= 1'b1;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

   // Fold E0/F0 prefixes into flags and emit one event per key byte or error
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         push      <= 1'b0;
         push_data <= '0;
      end else begin
         push <= 1'b0;
         if (err_stb) begin
            push      <= 1'b1;
            push_data <= {1'b1, 2'b00, 8'hFF};
            ext       <= 1'b0;
            brk       <= 1'b0;
         end else if (byte_stb) begin
            if (rx_byte == 8'hE0) begin
               ext <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
               brk <= 1'b1;
            end else begin
               push      <= 1'b1;
               push_data <= {1'b0, ext, brk, rx_byte};
               ext       <= 1'b0;
               brk       <= 1'b0;
            end
         end
      end
   end

   assign do_pop  = event_ready & (count != '0);
   assign do_push = push & ((count != CW'(FIFO_DEPTH)) | do_pop);

   // Next occupancy and next registered head word
   always_comb begin
      next_count = count;
      next_head  = '0;
      if (do_push && !do_pop) begin
         next_count = count + 1'b1;
      end else if (!do_push && do_pop) begin
         next_count = count - 1'b1;
      end
      // The head register is loaded from whichever word will sit at rd_ptr next:
      // the incoming push when the FIFO is (or becomes) a single entry, else memory.
      if (next_count == '0) begin
         next_head = '0;
      end else if (!do_pop) begin
         next_head = (count == '0) ? push_data : head;
      end else if (count == CW'(1)) begin
         next_head = push_data;
      end else begin
         next_head = mem[rd_ptr + 1'b1];
      end
   end

   // Storage array write port
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers, occupancy and registered head
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         head        <= '0;
         event_valid <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count       <= next_count;
         head        <= next_head;
         event_valid <= (next_count != '0);
      end
   end

   // Sticky drop indicator; a new drop outranks a simultaneous clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (push && !do_push) begin
         overflow <= 1'b1;
      end else if (clear_overflow) begin
         overflow <= 1'b0;
      end
   end

   assign keycode      = head[7:0];
   assign key_break    = head[8];
   assign key_extended = head[9];
   assign key_error    = head[10];
   assign fifo_count   = count;
   assign irq          = event_valid;

endmodule

// File: tb/tb_ps2kb_event_fifo.sv
// Scoreboard bench: a PS/2 device model drives frames, a reference decoder/queue
// predicts events, and a monitor compares every popped event against the queue.
module tb_ps2kb_event_fifo;

   localparam int OT = 200;
   localparam int D  = 8;
   localparam int S  = 2;
   localparam int H  = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       device_clock;
   logic       device_data;
   logic       event_valid;
   logic       event_ready;
   logic [7:0] keycode;
   logic       key_break;
   logic       key_extended;
   logic       key_error;
   logic [3:0] fifo_count;
   logic       overflow;
   logic       clear_overflow;
   logic       irq;

   ps2kb_event_fifo #(.OVER_TIME(OT), .FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
      .clock(clock), .reset(reset), .device_clock(device_clock), .device_data(device_data),
      .event_valid(event_valid), .event_ready(event_ready), .keycode(keycode),
      .key_break(key_break), .key_extended(key_extended), .key_error(key_error),
      .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow), .irq(irq)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q[$];
   bit m_ext, m_brk, m_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: prefixes set flags, other bytes and errors become events
   function automatic void m_event(input logic [10:0] ev);
      if (exp_q.size() >= D) m_ovf = 1'b1;
      else exp_q.push_back(ev);
   endfunction

   function automatic void m_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         m_event({1'b0, m_ext, m_brk, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   function automatic void m_error();
      m_event({1'b1, 2'b00, 8'hFF});
      m_ext = 1'b0;
      m_brk = 1'b0;
   endfunction

   // Monitor: compare each accepted head, and check empty outputs read zero
   always @(negedge clock) begin
      if (reset === 1'b0) begin
         if (event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event actual=%0h required=none",
                        {key_error, key_extended, key_break, keycode});
            end else begin
               chk("event", {key_error, key_extended, key_break, keycode}, exp_q.pop_front());
            end
         end else if (!event_valid) begin
            chk("empty_zero", {key_error, key_extended, key_break, keycode}, 0);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // mode 0: plain; 1: check valid latency; 2: pop exactly in the push cycle
   task automatic send_frame(input logic [7:0] b, input bit bad, input int mode);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         device_data = bits[i];
         cyc(H);
         device_clock = 1'b0;
         if (i == 10) begin
            if (mode == 2) begin
               cyc(S + 2);
               event_ready = 1'b1;
               cyc(1);
               event_ready = 1'b0;
            end
            if (bad) m_error();
            else m_byte(b);
            if (mode == 1) begin
               cyc(S + 2);
               chk("latency_before", event_valid, 0);
               cyc(1);
               chk("latency_at", event_valid, 1);
               cyc(H - S - 3);
            end else if (mode == 2) begin
               cyc(1);
               chk("full_pushpop_count", fifo_count, D);
               chk("full_pushpop_ovf", overflow, 0);
               cyc(H - S - 4);
            end else begin
               cyc(H);
            end
         end else begin
            cyc(H);
         end
         device_clock = 1'b1;
      end
      cyc(H);
   endtask

   task automatic send_bits(input int n);
      logic [7:0] b;
      b = 8'($urandom);
      for (int i = 0; i < n; i++) begin
         device_data = (i == 0) ? 1'b0 : b[i-1];
         cyc(H);
         device_clock = 1'b0;
         cyc(H);
         device_clock = 1'b1;
      end
   endtask

   task automatic drain();
      int k;
      event_ready = 1'b1;
      k = 0;
      while (event_valid && k < 100) begin
         cyc(1);
         k++;
      end
      if (event_valid) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=valid required=empty");
      end
      event_ready = 1'b0;
      cyc(2);
      chk("model_empty", exp_q.size(), 0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      reset = 1'b1;
      device_clock = 1'b1;
      device_data = 1'b1;
      event_ready = 1'b0;
      clear_overflow = 1'b0;
      cyc(3);
      chk("rst_valid", event_valid, 0);
      chk("rst_keycode", keycode, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_irq", irq, 0);
      reset = 1'b0;
      cyc(5);

      // single key with latency and pop
      send_frame(8'h1C, 1'b0, 1);
      chk("t1_count", fifo_count, 1);
      chk("t1_irq", irq, 1);
      chk("t1_keycode", keycode, 8'h1C);
      chk("t1_flags", {key_error, key_extended, key_break}, 0);
      event_ready = 1'b1;
      cyc(1);
      event_ready = 1'b0;
      cyc(1);
      chk("t1_valid_after_pop", event_valid, 0);
      chk("t1_keycode_after_pop", keycode, 0);
      chk("t1_count_after_pop", fifo_count, 0);

      // prefixes
      send_frame(8'hE0, 1'b0, 0);
      send_frame(8'hF0, 1'b0, 0);
      send_frame(8'h75, 1'b0, 0);
      chk("t2_count", fifo_count, 1);
      chk("t2_flags", {key_extended, key_break}, 2'b11);
      send_frame(8'h75, 1'b0, 0);
      chk("t2_count2", fifo_count, 2);
      drain();

      // parity error and timeout
      send_frame(8'h1C, 1'b1, 0);
      send_bits(5);
      m_error();
      cyc(OT + 20);
      chk("t3_count", fifo_count, 2);
      chk("t3_head", {key_error, keycode}, 9'h1FF);
      send_frame(8'h1C, 1'b0, 0);
      drain();

      // overflow
      for (int i = 1; i <= D + 1; i++) send_frame(8'(i), 1'b0, 0);
      chk("t4_count", fifo_count, D);
      chk("t4_ovf", overflow, m_ovf);
      drain();
      chk("t4_ovf_sticky", overflow, 1);
      clear_overflow = 1'b1;
      cyc(1);
      clear_overflow = 1'b0;
      m_ovf = 1'b0;
      cyc(1);
      chk("t4_ovf_clear", overflow, 0);

      // push and pop together while full
      for (int i = 0; i < D; i++) send_frame(8'(8'h21 + i), 1'b0, 0);
      chk("t5_full", fifo_count, D);
      send_frame(8'h21 + 8'(D), 1'b0, 2);
      chk("t5_count_after", fifo_count, D);
      chk("t5_ovf_after", overflow, 0);
      drain();

      // reset mid-frame with events queued
      for (int i = 0; i < 3; i++) send_frame(8'(8'h31 + i), 1'b0, 0);
      chk("t6_count", fifo_count, 3);
      send_bits(5);
      reset = 1'b1;
      exp_q.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_ovf = 1'b0;
      cyc(2);
      chk("t6_rst_valid", event_valid, 0);
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_fields", {key_error, key_extended, key_break, keycode}, 0);
      chk("t6_rst_irq", irq, 0);
      reset = 1'b0;
      cyc(5);
      send_frame(8'h5A, 1'b0, 1);
      chk("t6_after_key", keycode, 8'h5A);
      drain();

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         event_ready = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = 8'hE0;
            1: b = 8'hF0;
            default: b = 8'($urandom);
         endcase
         send_frame(b, ($urandom_range(0, 7) == 0), 0);
      end
      drain();
      chk("rand_ovf", overflow, m_ovf);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
